// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte width, ACK polarity, default target address
// and the state encodings used by the bus master and the register-file target.
package i2c_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Acknowledge polarity on SDA: a pulled-low ninth bit acknowledges.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

    // Target (register-file slave) states.
    localparam logic [3:0] T_IDLE    = 4'd0;
    localparam logic [3:0] T_DEV     = 4'd1;
    localparam logic [3:0] T_ACK_DEV = 4'd2;
    localparam logic [3:0] T_REG     = 4'd3;
    localparam logic [3:0] T_ACK_REG = 4'd4;
    localparam logic [3:0] T_WDATA   = 4'd5;
    localparam logic [3:0] T_ACK_WR  = 4'd6;
    localparam logic [3:0] T_RDATA   = 4'd7;
    localparam logic [3:0] T_MACK    = 4'd8;
    localparam logic [3:0] T_IGNORE  = 4'd9;

    // Master states, kept here so both ends of the bus share one definition.
    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_START = 3'd1;
    localparam logic [2:0] M_ADDR  = 3'd2;
    localparam logic [2:0] M_WRITE = 3'd3;
    localparam logic [2:0] M_READ  = 3'd4;
    localparam logic [2:0] M_ACK   = 3'd5;
    localparam logic [2:0] M_STOP  = 3'd6;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchroniser with one edge-detect register. Produces SCL edge
// strobes, the synchronised SDA level and START/STOP detection.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_d;
    logic                   scl_prev_q;
    logic                   scl_prev_d;
    logic                   sda_prev_q;
    logic                   sda_prev_d;
    logic                   scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Shift the raw pins through the synchroniser chain and remember the last synchronised level.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Synchroniser and edge-detect flops; reset to the idle (released, high) bus level so no edge fires after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // Event decode: SDA moving while SCL is stably high marks START/STOP.
    always_comb begin
        scl_rise  = scl_s & ~scl_prev_q;
        scl_fall  = ~scl_s & scl_prev_q;
        start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target serving a small 8-bit register bank: device-address match,
// register-pointer load, auto-incrementing writes and reads after a repeated
// START. The bank is also readable combinationally from a host-side port.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SCL_in,
    input  logic                        SDA_in,
    output logic                        SDA_out,
    output logic                        wr_strobe,
    output logic [7:0]                  wr_addr,
    output logic [7:0]                  wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] host_addr,
    output logic [7:0]                  host_rdata,
    output logic                        busy
);

    localparam int PTR_W = $clog2(NUM_REGS);

    logic scl_rise;
    logic scl_fall;
    logic sda_s;
    logic start_det;
    logic stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (SCL_in),
        .sda_in    (SDA_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    logic [3:0]       state_q,     state_d;
    logic [3:0]       bit_cnt_q,   bit_cnt_d;
    byte_t            shift_q,     shift_d;
    byte_t            tx_q,        tx_d;
    logic [PTR_W-1:0] ptr_q,       ptr_d;
    logic             rw_q,        rw_d;
    logic             ack_ph_q,    ack_ph_d;
    logic             sda_out_q,   sda_out_d;
    logic             busy_q,      busy_d;
    logic             wr_strobe_q, wr_strobe_d;
    byte_t            wr_addr_q,   wr_addr_d;
    byte_t            wr_data_q,   wr_data_d;
    byte_t            bank_q [NUM_REGS];
    byte_t            bank_d [NUM_REGS];

    byte_t            rx_byte_s;
    logic [PTR_W-1:0] ptr_inc_s;

    // Byte as it stands once the bit currently on the bus is shifted in (MSB first).
    assign rx_byte_s = {shift_q[BYTE_W-2:0], sda_s};
    assign ptr_inc_s = ptr_q + PTR_W'(1);

    // Target FSM: START/STOP override everything, otherwise per-state bit handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ack_ph_d    = ack_ph_q;
        sda_out_d   = sda_out_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        bank_d      = bank_q;

        if (start_det) begin
            // Also covers repeated START: any partial byte is dropped, the pointer is kept.
            state_d   = T_DEV;
            bit_cnt_d = 4'd0;
            ack_ph_d  = 1'b0;
            sda_out_d = 1'b1;
        end else if (stop_det) begin
            state_d   = T_IDLE;
            bit_cnt_d = 4'd0;
            ack_ph_d  = 1'b0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                T_IDLE: begin
                    sda_out_d = 1'b1;
                end

                T_DEV: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (rx_byte_s[7:1] == DEV_ADDR) begin
                                state_d = T_ACK_DEV;
                                rw_d    = rx_byte_s[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d   = T_IGNORE;
                                sda_out_d = 1'b1;
                                busy_d    = 1'b0;
                            end
                        end else begin
                            state_d = T_DEV;
                        end
                    end else begin
                        state_d = T_DEV;
                    end
                end

                T_ACK_DEV, T_ACK_REG, T_ACK_WR: begin
                    // First falling edge pulls SDA low for the ACK slot, the next one releases it.
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_out_d = ACK;
                            ack_ph_d  = 1'b1;
                        end else begin
                            sda_out_d = 1'b1;
                            ack_ph_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            case (state_q)
                                T_ACK_DEV: begin
                                    if (rw_q) begin
                                        state_d   = T_RDATA;
                                        tx_d      = bank_q[ptr_q];
                                        sda_out_d = bank_q[ptr_q][7];
                                    end else begin
                                        state_d = T_REG;
                                    end
                                end
                                T_ACK_REG: state_d = T_WDATA;
                                T_ACK_WR:  state_d = T_WDATA;
                                default:   state_d = T_IDLE;
                            endcase
                        end
                    end else begin
                        ack_ph_d = ack_ph_q;
                    end
                end

                T_REG: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            // The pointer only changes once the whole byte has arrived.
                            bit_cnt_d = 4'd0;
                            ptr_d     = rx_byte_s[PTR_W-1:0];
                            state_d   = T_ACK_REG;
                        end else begin
                            state_d = T_REG;
                        end
                    end else begin
                        state_d = T_REG;
                    end
                end

                T_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            // Commit the byte and advance the pointer in the same cycle.
                            bit_cnt_d     = 4'd0;
                            bank_d[ptr_q] = rx_byte_s;
                            wr_strobe_d   = 1'b1;
                            wr_addr_d     = 8'(ptr_q);
                            wr_data_d     = rx_byte_s;
                            ptr_d         = ptr_inc_s;
                            state_d       = T_ACK_WR;
                        end else begin
                            state_d = T_WDATA;
                        end
                    end else begin
                        state_d = T_WDATA;
                    end
                end

                T_RDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_q != 4'd8) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            // All eight bits shown: hand SDA back for the master's ACK/NACK.
                            sda_out_d = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = T_MACK;
                        end else begin
                            sda_out_d = tx_q[3'd7 - bit_cnt_q[2:0]];
                        end
                    end else begin
                        state_d = T_RDATA;
                    end
                end

                T_MACK: begin
                    if (scl_rise) begin
                        if (sda_s == ACK) begin
                            ptr_d     = ptr_inc_s;
                            tx_d      = bank_q[ptr_inc_s];
                            bit_cnt_d = 4'd0;
                            state_d   = T_RDATA;
                        end else begin
                            state_d = T_IGNORE;
                        end
                    end else begin
                        state_d = T_MACK;
                    end
                end

                T_IGNORE: begin
                    sda_out_d = 1'b1;
                end

                default: begin
                    state_d   = T_IDLE;
                    sda_out_d = 1'b1;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    // Control, pointer and output registers; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= T_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            ack_ph_q    <= 1'b0;
            sda_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ack_ph_q    <= ack_ph_d;
            sda_out_q   <= sda_out_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register bank storage, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign SDA_out    = sda_out_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign host_rdata = bank_q[host_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a behavioural bus master drives
// SCL/SDA (half-period 4 clk) and checks ACK slots, read data, commits and
// host-side bank contents against hand-computed values.
module tb_i2c_slave_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       SDA_out;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] host_addr = 4'd3;
    logic [7:0] host_rdata;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int         strobe_cnt = 0;
    int         sda_low_cnt = 0;
    int         busy_cnt = 0;
    logic [7:0] last_wa = 8'h00;
    logic [7:0] last_wd = 8'h00;

    assign sda_bus = m_sda & SDA_out;

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .DEV_ADDR    (7'h50),
        .NUM_REGS    (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SCL_in     (m_scl),
        .SDA_in     (sda_bus),
        .SDA_out    (SDA_out),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .busy       (busy)
    );

    // Bus monitor: counts commits, cycles with SDA pulled low, and busy cycles.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            last_wa    <= wr_addr;
            last_wd    <= wr_data;
        end
        if (!SDA_out) sda_low_cnt <= sda_low_cnt + 1;
        if (busy)     busy_cnt    <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period starting and ending with SCL low; returns the target's drive at the sample point.
    task automatic bit_tx(input logic b, output logic dut_sda);
        tick(1); m_sda = b;
        tick(3); m_scl = 1'b1;
        tick(3); dut_sda = SDA_out;
        tick(1); m_scl = 1'b0;
    endtask

    task automatic do_start();
        tick(1); m_sda = 1'b1;
        tick(3); m_scl = 1'b1;
        tick(4); m_sda = 1'b0;
        tick(4); m_scl = 1'b0;
    endtask

    task automatic do_stop();
        tick(1); m_sda = 1'b0;
        tick(3); m_scl = 1'b1;
        tick(4); m_sda = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_drv);
        logic d;
        for (int i = 7; i >= 0; i--) bit_tx(b[i], d);
        bit_tx(1'b1, ack_drv);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] data, output logic ack_slot);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            bit_tx(1'b1, d);
            data[i] = d;
        end
        bit_tx(mack, ack_slot);
    endtask

    task automatic host_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        chk(tag, {24'h0, host_rdata}, {24'h0, exp});
    endtask

    initial begin
        logic       a;
        logic [7:0] rd;
        logic       d;
        int         s0, l0, b0;

        // Reset state
        tick(4);
        chk("rst_sda_in_reset", {31'h0, SDA_out}, 32'd1);
        rst = 1'b1;
        tick(4);
        chk("rst_sda", {31'h0, SDA_out}, 32'd1);
        chk("rst_strobe", {31'h0, wr_strobe}, 32'd0);
        chk("rst_waddr", {24'h0, wr_addr}, 32'h0);
        chk("rst_wdata", {24'h0, wr_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        host_chk("rst_bank3", 4'd3, 8'h00);

        // Single write 0x50 / reg 0x03 / 0xA5
        s0 = strobe_cnt;
        do_start();
        send_byte(8'hA0, a); chk("t1_ack_dev", {31'h0, a}, 32'd0);
        #1 chk("t1_busy", {31'h0, busy}, 32'd1);
        send_byte(8'h03, a); chk("t1_ack_reg", {31'h0, a}, 32'd0);
        send_byte(8'hA5, a); chk("t1_ack_wr", {31'h0, a}, 32'd0);
        do_stop();
        chk("t1_strobes", strobe_cnt - s0, 32'd1);
        chk("t1_waddr", {24'h0, last_wa}, 32'h03);
        chk("t1_wdata", {24'h0, last_wd}, 32'hA5);
        chk("t1_busy_after_stop", {31'h0, busy}, 32'd0);
        host_chk("t1_bank3", 4'd3, 8'hA5);

        // Burst write from reg 0x0F wraps to 0
        s0 = strobe_cnt;
        do_start();
        send_byte(8'hA0, a); chk("t2_ack_dev", {31'h0, a}, 32'd0);
        send_byte(8'h0F, a); chk("t2_ack_reg", {31'h0, a}, 32'd0);
        send_byte(8'h11, a); chk("t2_ack_wr0", {31'h0, a}, 32'd0);
        send_byte(8'h22, a); chk("t2_ack_wr1", {31'h0, a}, 32'd0);
        do_stop();
        chk("t2_strobes", strobe_cnt - s0, 32'd2);
        chk("t2_last_waddr", {24'h0, last_wa}, 32'h00);
        host_chk("t2_bank15", 4'd15, 8'h11);
        host_chk("t2_bank0", 4'd0, 8'h22);
        host_chk("t2_bank3_kept", 4'd3, 8'hA5);

        // Pointer set, repeated START, read with NACK, then ignored until STOP
        do_start();
        send_byte(8'hA0, a); chk("t3_ack_dev", {31'h0, a}, 32'd0);
        send_byte(8'h03, a); chk("t3_ack_reg", {31'h0, a}, 32'd0);
        do_start();
        send_byte(8'hA1, a); chk("t3_ack_rd", {31'h0, a}, 32'd0);
        read_byte(1'b1, rd, a);
        chk("t3_rdata", {24'h0, rd}, 32'hA5);
        chk("t3_nack_slot_released", {31'h0, a}, 32'd1);
        l0 = sda_low_cnt;
        send_byte(8'h00, a);
        chk("t3_ignore_ack", {31'h0, a}, 32'd1);
        chk("t3_ignore_sda_low", sda_low_cnt - l0, 32'd0);
        do_stop();
        chk("t3_busy_after_stop", {31'h0, busy}, 32'd0);

        // Wrong address 0x51: never driven, never busy, no commit
        s0 = strobe_cnt; l0 = sda_low_cnt; b0 = busy_cnt;
        do_start();
        send_byte(8'hA2, a); chk("t4_nack_dev", {31'h0, a}, 32'd1);
        send_byte(8'h5A, a);
        send_byte(8'h77, a);
        do_stop();
        chk("t4_sda_low", sda_low_cnt - l0, 32'd0);
        chk("t4_busy", busy_cnt - b0, 32'd0);
        chk("t4_strobes", strobe_cnt - s0, 32'd0);

        // Reset in the middle of WDATA bit 4
        do_start();
        send_byte(8'hA0, a);
        send_byte(8'h05, a);
        bit_tx(1'b1, d); bit_tx(1'b0, d); bit_tx(1'b1, d);
        tick(1); m_sda = 1'b1;
        tick(3); m_scl = 1'b1;
        tick(2); rst = 1'b0;
        #1;
        chk("t5_sda_at_reset", {31'h0, SDA_out}, 32'd1);
        chk("t5_busy_at_reset", {31'h0, busy}, 32'd0);
        host_chk("t5_bank3_clr", 4'd3, 8'h00);
        host_chk("t5_bank15_clr", 4'd15, 8'h00);
        host_chk("t5_bank0_clr", 4'd0, 8'h00);
        tick(4); rst = 1'b1;
        tick(8);
        s0 = strobe_cnt;
        do_start();
        send_byte(8'hA0, a); chk("t5_ack_dev", {31'h0, a}, 32'd0);
        send_byte(8'h07, a); chk("t5_ack_reg", {31'h0, a}, 32'd0);
        send_byte(8'h3C, a); chk("t5_ack_wr", {31'h0, a}, 32'd0);
        do_stop();
        chk("t5_strobes", strobe_cnt - s0, 32'd1);
        chk("t5_waddr", {24'h0, last_wa}, 32'h07);
        host_chk("t5_bank7", 4'd7, 8'h3C);

        // START mid-REG byte discards the partial pointer
        s0 = strobe_cnt;
        do_start();
        send_byte(8'hA0, a);
        send_byte(8'h07, a);
        do_start();
        send_byte(8'hA0, a); chk("t6_ack_dev", {31'h0, a}, 32'd0);
        bit_tx(1'b1, d); bit_tx(1'b1, d); bit_tx(1'b1, d); bit_tx(1'b1, d);
        do_start();
        send_byte(8'hA1, a); chk("t6_ack_rd", {31'h0, a}, 32'd0);
        read_byte(1'b1, rd, a);
        chk("t6_rdata_ptr_kept", {24'h0, rd}, 32'h3C);
        do_stop();
        chk("t6_strobes", strobe_cnt - s0, 32'd0);
        chk("t6_busy_after_stop", {31'h0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
